// File: rtl/tmr_pkg.sv
// Shared constants for the dual-channel timer register bank: address map, reset values, FSM states, TCSR bit positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tmr_pkg;

    // Register offsets inside a channel; address bit 3 selects channel 1.
    localparam logic [2:0] REG_TCR   = 3'd0;
    localparam logic [2:0] REG_TCSR  = 3'd1;
    localparam logic [2:0] REG_TCORA = 3'd2;
    localparam logic [2:0] REG_TCORB = 3'd3;
    localparam logic [2:0] REG_TCCR  = 3'd4;
    localparam int         CH_SEL_BIT = 3;
    localparam logic [3:0] CH1_BASE   = 4'h8;

    localparam logic [7:0] TCR_RST   = 8'h00;
    localparam logic [7:0] TCCR_RST  = 8'h00;
    localparam logic [7:0] TCSR_RST  = 8'h00;
    localparam logic [7:0] TCORA_RST = 8'hFF;
    localparam logic [7:0] TCORB_RST = 8'hFF;

    localparam logic [7:0] UNMAPPED_RD = 8'hFF;
    localparam logic [7:0] TCCR_WMASK  = 8'h0B;
    localparam logic [7:0] TCSR0_WMASK = 8'h1F;
    localparam logic [7:0] TCSR1_WMASK = 8'h0F;

    localparam int TCSR_OVF  = 5;
    localparam int TCSR_CMFA = 6;
    localparam int TCSR_CMFB = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/tmr_flag_ctl.sv
// One TCSR status flag: hardware set, read-arm, software clear, set beats clear (TMR_FLAG_RMW_CLEAR_EN enables arming).
// Latency: flag updates one cycle after set_evt / strobes.
// Backpressure: none; strobes are single-cycle pulses from the bus FSM.
module tmr_flag_ctl (
    input  logic clk,
    input  logic rst,
    input  logic set_evt,
    input  logic rd_sample,
    input  logic wr_clr,
    output logic flag
);

    logic flag_q;

`ifdef TMR_FLAG_RMW_CLEAR_EN
    logic arm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
            arm_q  <= 1'b0;
        end else if (set_evt) begin
            // A colliding clear loses, but still consumes the arm.
            flag_q <= 1'b1;
            if (wr_clr)
                arm_q <= 1'b0;
        end else if (wr_clr && arm_q) begin
            flag_q <= 1'b0;
            arm_q  <= 1'b0;
        end else if (rd_sample && flag_q) begin
            arm_q <= 1'b1;
        end
    end
`else
    logic unused_rd_sample;
    assign unused_rd_sample = rd_sample;

    always_ff @(posedge clk) begin
        if (rst)
            flag_q <= 1'b0;
        else if (set_evt)
            flag_q <= 1'b1;
        else if (wr_clr)
            flag_q <= 1'b0;
    end
`endif

    assign flag = flag_q;

endmodule

// File: rtl/tmr_reg_bank.sv
// Two-channel timer register bank behind a req/ack bus (IDLE->ACK->WAIT); TMR_FLAG_RMW_CLEAR_EN selects read-then-write flag clearing.
// Latency: bus_ack and bus_rdata one cycle after bus_req sampled in IDLE; writes commit on that same edge.
// Backpressure: requester holds bus_req until ack, then must drop it before the next access is taken.
module tmr_reg_bank
    import tmr_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [BIT_WIDTH-1:0]  bus_wdata,
    output logic [BIT_WIDTH-1:0]  bus_rdata,
    output logic                  bus_ack,
    input  logic                  CompareMatchA0,
    input  logic                  CompareMatchA1,
    input  logic                  CompareMatchB0,
    input  logic                  CompareMatchB1,
    input  logic                  Overflow0,
    input  logic                  Overflow1,
    output logic [BIT_WIDTH-1:0]  TCR_0,
    output logic [BIT_WIDTH-1:0]  TCR_1,
    output logic [BIT_WIDTH-1:0]  TCCR_0,
    output logic [BIT_WIDTH-1:0]  TCCR_1,
    output logic [BIT_WIDTH-1:0]  TCSR_0,
    output logic [BIT_WIDTH-1:0]  TCSR_1,
    output logic [BIT_WIDTH-1:0]  TCORA_0,
    output logic [BIT_WIDTH-1:0]  TCORA_1,
    output logic [BIT_WIDTH-1:0]  TCORB_0,
    output logic [BIT_WIDTH-1:0]  TCORB_1
);

    tmr_state_e           state;
    logic [BIT_WIDTH-1:0] tcr_q     [2];
    logic [BIT_WIDTH-1:0] tccr_q    [2];
    logic [BIT_WIDTH-1:0] tcsr_lo_q [2];
    logic [BIT_WIDTH-1:0] tcora_q   [2];
    logic [BIT_WIDTH-1:0] tcorb_q   [2];
    logic [BIT_WIDTH-1:0] tcsr_val  [2];
    logic [BIT_WIDTH-1:0] rd_val;
    logic [1:0][2:0]      flag;
    logic [1:0][2:0]      evt;
    logic [1:0]           tcsr_rd;
    logic [1:0]           tcsr_wr;
    logic                 ch;
    logic [2:0]           off;
    logic                 mapped;
    logic                 take;
    logic                 wr_stb;
    logic                 rd_stb;

    assign ch     = bus_addr[CH_SEL_BIT];
    assign off    = bus_addr[2:0];
    assign mapped = ((bus_addr >> 4) == '0) && (off <= REG_TCCR);
    assign take   = (state == ST_IDLE) && bus_req;
    assign wr_stb = take && bus_we && mapped;
    assign rd_stb = take && !bus_we && mapped;

    always_comb begin
        rd_val = BIT_WIDTH'(UNMAPPED_RD);
        if (mapped) begin
            case (off)
                REG_TCR:   rd_val = tcr_q[ch];
                REG_TCSR:  rd_val = tcsr_val[ch];
                REG_TCORA: rd_val = tcora_q[ch];
                REG_TCORB: rd_val = tcorb_q[ch];
                REG_TCCR:  rd_val = tccr_q[ch];
                default:   rd_val = BIT_WIDTH'(UNMAPPED_RD);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus_req) begin
                    state     <= ST_ACK;
                    bus_ack   <= 1'b1;
                    bus_rdata <= bus_we ? '0 : rd_val;
                end
                ST_ACK: begin
                    state     <= ST_WAIT;
                    bus_ack   <= 1'b0;
                    bus_rdata <= '0;
                end
                ST_WAIT: if (!bus_req)
                    state <= ST_IDLE;
                default: begin
                    state     <= ST_IDLE;
                    bus_ack   <= 1'b0;
                    bus_rdata <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                tcr_q[c]     <= BIT_WIDTH'(TCR_RST);
                tccr_q[c]    <= BIT_WIDTH'(TCCR_RST);
                tcsr_lo_q[c] <= BIT_WIDTH'(TCSR_RST);
                tcora_q[c]   <= BIT_WIDTH'(TCORA_RST);
                tcorb_q[c]   <= BIT_WIDTH'(TCORB_RST);
            end
        end else if (wr_stb) begin
            case (off)
                REG_TCR:   tcr_q[ch]   <= bus_wdata;
                REG_TCORA: tcora_q[ch] <= bus_wdata;
                REG_TCORB: tcorb_q[ch] <= bus_wdata;
                REG_TCCR:  tccr_q[ch]  <= bus_wdata & BIT_WIDTH'(TCCR_WMASK);
                REG_TCSR:  tcsr_lo_q[ch] <= bus_wdata &
                               BIT_WIDTH'(ch ? TCSR1_WMASK : TCSR0_WMASK);
                default: ;
            endcase
        end
    end

    assign evt[0] = {CompareMatchB0, CompareMatchA0, Overflow0};
    assign evt[1] = {CompareMatchB1, CompareMatchA1, Overflow1};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        assign tcsr_rd[c]  = rd_stb && (off == REG_TCSR) && (ch == 1'(c));
        assign tcsr_wr[c]  = wr_stb && (off == REG_TCSR) && (ch == 1'(c));
        assign tcsr_val[c] = tcsr_lo_q[c] | (BIT_WIDTH'(flag[c]) << TCSR_OVF);
        for (genvar k = 0; k < 3; k++) begin : g_bit
            tmr_flag_ctl u_flag (
                .clk       (clk),
                .rst       (rst),
                .set_evt   (evt[c][k]),
                .rd_sample (tcsr_rd[c]),
                .wr_clr    (tcsr_wr[c] && !bus_wdata[TCSR_OVF + k]),
                .flag      (flag[c][k])
            );
        end
    end

    assign TCR_0   = tcr_q[0];
    assign TCR_1   = tcr_q[1];
    assign TCCR_0  = tccr_q[0];
    assign TCCR_1  = tccr_q[1];
    assign TCSR_0  = tcsr_val[0];
    assign TCSR_1  = tcsr_val[1];
    assign TCORA_0 = tcora_q[0];
    assign TCORA_1 = tcora_q[1];
    assign TCORB_0 = tcorb_q[0];
    assign TCORB_1 = tcorb_q[1];

endmodule
